// File: rtl/multiwatch_core.sv
// Multi-channel stopwatch core: N_CH independent channels sharing one prescaler,
// one button set steering the selected channel, registered display of time or lap.
module multiwatch_core #(
  parameter int N_CH     = 4,
  parameter int TICK_DIV = 1000000,
  parameter int HOUR_MAX = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    btn_sel,
  input  logic                    btn_run,
  input  logic                    btn_clr,
  input  logic                    btn_lap,
  output logic [23:0]             disp_data,
  output logic [$clog2(N_CH)-1:0] ch_sel,
  output logic [N_CH-1:0]         ch_running,
  output logic                    lap_active
);

  localparam int SW = $clog2(N_CH);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STOP} state_t;

  logic [PW-1:0]   r_presc;
  logic            w_tick;
  logic [SW-1:0]   r_sel;
  logic            r_lap_active;
  logic [23:0]     r_lap;
  logic [23:0]     r_disp;
  logic [N_CH-1:0] r_running;
  logic            r_lap_out;

  logic            w_do_sel, w_do_clr, w_do_run, w_do_lap;
  logic [N_CH-1:0] w_running;
  logic [N_CH-1:0] w_clr_vec;
  logic [23:0]     w_time_arr [N_CH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
    end else if (r_presc == PW'(TICK_DIV - 1)) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  assign w_tick = (r_presc == PW'(TICK_DIV - 1));

  // Only the highest-priority pulse survives: sel > clr > run > lap.
  assign w_do_sel = btn_sel;
  assign w_do_clr = btn_clr & ~btn_sel;
  assign w_do_run = btn_run & ~btn_sel & ~btn_clr;
  assign w_do_lap = btn_lap & ~btn_sel & ~btn_clr & ~btn_run;

  function automatic logic [23:0] inc_time(input logic [23:0] t);
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic [6:0] c;
    {h, m, s, c} = t;
    if (c != 7'd99) begin
      c = c + 7'd1;
    end else begin
      c = '0;
      if (s != 6'd59) begin
        s = s + 6'd1;
      end else begin
        s = '0;
        if (m != 6'd59) begin
          m = m + 6'd1;
        end else begin
          m = '0;
          h = (h != 5'(HOUR_MAX - 1)) ? h + 5'd1 : '0;
        end
      end
    end
    return {h, m, s, c};
  endfunction

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    state_t      r_state;
    state_t      w_state_nxt;
    logic [23:0] r_time;
    logic [23:0] w_time_nxt;
    logic        w_sel_me;
    logic        w_clr_eff;

    assign w_sel_me = (r_sel == SW'(gi));

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state <= ST_IDLE;
        r_time  <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_time  <= w_time_nxt;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      if (w_sel_me) begin
        case (r_state)
          ST_IDLE: if (w_do_run) w_state_nxt = ST_RUN;
          ST_RUN:  if (w_do_run) w_state_nxt = ST_STOP;
          ST_STOP: begin
            if (w_do_run)      w_state_nxt = ST_RUN;
            else if (w_do_clr) w_state_nxt = ST_IDLE;
          end
          default: w_state_nxt = ST_IDLE;
        endcase
      end
    end

    // Counting is decided by the state at the start of the cycle, not w_state_nxt.
    always_comb begin
      w_clr_eff  = w_sel_me & w_do_clr & (r_state == ST_STOP);
      w_time_nxt = r_time;
      if (w_clr_eff) begin
        w_time_nxt = '0;
      end else if (w_tick && (r_state == ST_RUN)) begin
        w_time_nxt = inc_time(r_time);
      end
    end

    assign w_running[gi]  = (r_state == ST_RUN);
    assign w_clr_vec[gi]  = w_clr_eff;
    assign w_time_arr[gi] = r_time;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel        <= '0;
      r_lap_active <= 1'b0;
      r_lap        <= '0;
    end else begin
      if (w_do_sel) begin
        r_sel <= (r_sel == SW'(N_CH - 1)) ? '0 : r_sel + 1'b1;
      end
      if (w_do_sel || (|w_clr_vec)) begin
        r_lap_active <= 1'b0;
      end else if (w_do_lap) begin
        if (r_lap_active) begin
          r_lap_active <= 1'b0;
        end else if (w_running[r_sel]) begin
          r_lap_active <= 1'b1;
          r_lap        <= w_time_arr[r_sel];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_disp    <= '0;
      r_running <= '0;
      r_lap_out <= 1'b0;
    end else begin
      r_disp    <= r_lap_active ? r_lap : w_time_arr[r_sel];
      r_running <= w_running;
      r_lap_out <= r_lap_active;
    end
  end

  assign disp_data  = r_disp;
  assign ch_sel     = r_sel;
  assign ch_running = r_running;
  assign lap_active = r_lap_out;

endmodule

// File: tb/tb_multiwatch_core.sv
// Directed bench for multiwatch_core with a 4-cycle tick; expected times are
// derived from edge counts after reset (ticks land on every 4th edge).
module tb_multiwatch_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_sel = 1'b0;
  logic        btn_run = 1'b0;
  logic        btn_clr = 1'b0;
  logic        btn_lap = 1'b0;
  logic [23:0] disp_data;
  logic [1:0]  ch_sel;
  logic [3:0]  ch_running;
  logic        lap_active;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [23:0] T_MAX = {5'd23, 6'd59, 6'd59, 7'd99};

  multiwatch_core #(.N_CH(4), .TICK_DIV(4), .HOUR_MAX(24)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_sel    (btn_sel),
    .btn_run    (btn_run),
    .btn_clr    (btn_clr),
    .btn_lap    (btn_lap),
    .disp_data  (disp_data),
    .ch_sel     (ch_sel),
    .ch_running (ch_running),
    .lap_active (lap_active)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] tm(input int h, input int m, input int s, input int c);
    return {5'(h), 6'(m), 6'(s), 7'(c)};
  endfunction

  // All tasks are entered just after a negedge; the reset edge is E0.
  task automatic do_reset();
    rst = 1'b1; btn_sel = 0; btn_run = 0; btn_clr = 0; btn_lap = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse(input logic s, input logic r, input logic c, input logic l);
    btn_sel = s; btn_run = r; btn_clr = c; btn_lap = l;
    @(negedge clk);
    btn_sel = 0; btn_run = 0; btn_clr = 0; btn_lap = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (disp_data !== 24'd0 || ch_sel !== 2'd0 || ch_running !== 4'd0 || lap_active !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: disp=%h sel=%0d run=%b lap=%b, expected all 0", disp_data, ch_sel, ch_running, lap_active);
    end
  endtask

  task automatic test_count_carry();
    do_reset();
    pulse(0, 1, 0, 0);                // RUN at E1
    repeat (399) @(negedge clk);      // after E400: shows time at E399
    n_tests++;
    if (disp_data !== tm(0, 0, 0, 99)) begin
      n_fail++; $display("FAIL count_99: disp=%h expected %h", disp_data, tm(0, 0, 0, 99));
    end
    @(negedge clk);
    n_tests++;
    if (disp_data !== tm(0, 0, 1, 0) || ch_running !== 4'b0001) begin
      n_fail++; $display("FAIL count_100: disp=%h run=%b expected %h 0001", disp_data, ch_running, tm(0, 0, 1, 0));
    end
    repeat (23599) @(negedge clk);    // after E24000
    n_tests++;
    if (disp_data !== tm(0, 0, 59, 99)) begin
      n_fail++; $display("FAIL carry_pre: disp=%h expected %h", disp_data, tm(0, 0, 59, 99));
    end
    @(negedge clk);
    n_tests++;
    if (disp_data !== tm(0, 1, 0, 0)) begin
      n_fail++; $display("FAIL carry_min: disp=%h expected %h", disp_data, tm(0, 1, 0, 0));
    end
  endtask

  task automatic test_hour_wrap();
    bit seen;
    pulse(0, 1, 0, 0);                // ch0 -> STOP
    force dut.g_ch[0].r_time = T_MAX;
    repeat (3) @(negedge clk);
    n_tests++;
    if (disp_data !== T_MAX || ch_running !== 4'b0000) begin
      n_fail++; $display("FAIL wrap_preload: disp=%h run=%b expected %h 0000", disp_data, ch_running, T_MAX);
    end
    release dut.g_ch[0].r_time;
    @(negedge clk);
    pulse(0, 1, 0, 0);                // back to RUN
    seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (disp_data !== T_MAX) seen = 1;
    end
    n_tests++;
    if (disp_data !== 24'd0) begin
      n_fail++; $display("FAIL hour_wrap: disp=%h expected 000000", disp_data);
    end
  endtask

  task automatic test_multi_channel();
    do_reset();
    pulse(0, 1, 0, 0);                // E1 ch0 RUN
    pulse(1, 0, 0, 0);                // E2 select ch1
    n_tests++;
    if (ch_sel !== 2'd1) begin
      n_fail++; $display("FAIL sel_1: ch_sel=%0d expected 1", ch_sel);
    end
    pulse(0, 1, 0, 0);                // E3 ch1 RUN
    repeat (38) @(negedge clk);       // after E41
    n_tests++;
    if (disp_data !== tm(0, 0, 0, 10) || ch_running !== 4'b0011) begin
      n_fail++; $display("FAIL two_run: disp=%h run=%b expected %h 0011", disp_data, ch_running, tm(0, 0, 0, 10));
    end
    pulse(0, 0, 1, 0);                // E42 clr on RUN ignored
    repeat (2) @(negedge clk);        // after E44
    n_tests++;
    if (disp_data !== tm(0, 0, 0, 10) || ch_running !== 4'b0011) begin
      n_fail++; $display("FAIL clr_in_run: disp=%h run=%b expected %h 0011", disp_data, ch_running, tm(0, 0, 0, 10));
    end
    pulse(1, 0, 0, 0);
    pulse(1, 0, 0, 0);
    n_tests++;
    if (ch_sel !== 2'd3) begin
      n_fail++; $display("FAIL sel_3: ch_sel=%0d expected 3", ch_sel);
    end
    pulse(1, 0, 0, 0);                // E47 wrap to 0
    n_tests++;
    if (ch_sel !== 2'd0) begin
      n_fail++; $display("FAIL sel_wrap: ch_sel=%0d expected 0", ch_sel);
    end
    @(negedge clk);                   // after E48: ch0 time at E47
    n_tests++;
    if (disp_data !== tm(0, 0, 0, 11)) begin
      n_fail++; $display("FAIL ch0_continues: disp=%h expected %h", disp_data, tm(0, 0, 0, 11));
    end
  endtask

  task automatic test_lap();
    int bad;
    do_reset();
    pulse(0, 1, 0, 0);                // E1
    repeat (19) @(negedge clk);       // after E20, time 5
    pulse(0, 0, 0, 1);                // E21 latch 5
    @(negedge clk);                   // after E22
    n_tests++;
    if (lap_active !== 1'b1 || disp_data !== tm(0, 0, 0, 5)) begin
      n_fail++; $display("FAIL lap_on: lap=%b disp=%h expected 1 %h", lap_active, disp_data, tm(0, 0, 0, 5));
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (disp_data !== tm(0, 0, 0, 5) || lap_active !== 1'b1) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL lap_frozen: %0d cycles differed, expected 0", bad);
    end
    pulse(0, 0, 0, 1);                // E43 lap off
    @(negedge clk);                   // after E44: time at E43
    n_tests++;
    if (lap_active !== 1'b0 || disp_data !== tm(0, 0, 0, 10)) begin
      n_fail++; $display("FAIL lap_off: lap=%b disp=%h expected 0 %h", lap_active, disp_data, tm(0, 0, 0, 10));
    end
  endtask

  task automatic test_priority();
    do_reset();
    pulse(1, 1, 0, 0);                // E1 sel wins over run
    @(negedge clk);
    n_tests++;
    if (ch_sel !== 2'd1 || ch_running !== 4'b0000) begin
      n_fail++; $display("FAIL sel_over_run: sel=%0d run=%b expected 1 0000", ch_sel, ch_running);
    end
    pulse(0, 1, 0, 0);                // ch1 RUN
    pulse(0, 1, 1, 0);                // clr wins (ignored in RUN), run dropped
    @(negedge clk);
    n_tests++;
    if (ch_running !== 4'b0010) begin
      n_fail++; $display("FAIL clr_over_run: run=%b expected 0010", ch_running);
    end
    pulse(0, 1, 0, 1);                // run wins, lap dropped
    @(negedge clk);
    n_tests++;
    if (ch_running !== 4'b0000 || lap_active !== 1'b0) begin
      n_fail++; $display("FAIL run_over_lap: run=%b lap=%b expected 0000 0", ch_running, lap_active);
    end
  endtask

  task automatic test_tick_edges();
    do_reset();
    repeat (3) @(negedge clk);        // after E3
    pulse(0, 1, 0, 0);                // E4 is a tick edge
    @(negedge clk);                   // after E5
    n_tests++;
    if (disp_data !== 24'd0 || ch_running !== 4'b0001) begin
      n_fail++; $display("FAIL start_on_tick: disp=%h run=%b expected 000000 0001", disp_data, ch_running);
    end
    repeat (4) @(negedge clk);        // after E9
    n_tests++;
    if (disp_data !== tm(0, 0, 0, 1)) begin
      n_fail++; $display("FAIL first_tick: disp=%h expected %h", disp_data, tm(0, 0, 0, 1));
    end
    repeat (2) @(negedge clk);        // after E11
    pulse(0, 1, 0, 0);                // E12 stop on tick edge: still counts
    @(negedge clk);
    n_tests++;
    if (disp_data !== tm(0, 0, 0, 2) || ch_running !== 4'b0000) begin
      n_fail++; $display("FAIL stop_on_tick: disp=%h run=%b expected %h 0000", disp_data, ch_running, tm(0, 0, 0, 2));
    end
    repeat (8) @(negedge clk);
    n_tests++;
    if (disp_data !== tm(0, 0, 0, 2)) begin
      n_fail++; $display("FAIL stop_holds: disp=%h expected %h", disp_data, tm(0, 0, 0, 2));
    end
    pulse(0, 0, 1, 0);                // STOP + clr -> IDLE, 0
    @(negedge clk);
    n_tests++;
    if (disp_data !== 24'd0 || ch_running !== 4'b0000) begin
      n_fail++; $display("FAIL clr_in_stop: disp=%h run=%b expected 000000 0000", disp_data, ch_running);
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    pulse(0, 1, 0, 0);
    repeat (10) @(negedge clk);
    pulse(0, 0, 0, 1);
    repeat (2) @(negedge clk);
    n_tests++;
    if (lap_active !== 1'b1 || ch_running !== 4'b0001) begin
      n_fail++; $display("FAIL pre_rst: lap=%b run=%b expected 1 0001", lap_active, ch_running);
    end
    rst = 1'b1; btn_run = 1'b1; btn_sel = 1'b1;
    @(negedge clk);
    n_tests++;
    if (disp_data !== 24'd0 || ch_sel !== 2'd0 || ch_running !== 4'd0 || lap_active !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid: disp=%h sel=%0d run=%b lap=%b expected all 0", disp_data, ch_sel, ch_running, lap_active);
    end
    rst = 1'b0; btn_run = 1'b0; btn_sel = 1'b0;
    repeat (6) @(negedge clk);
    n_tests++;
    if (disp_data !== 24'd0 || ch_sel !== 2'd0 || ch_running !== 4'd0) begin
      n_fail++; $display("FAIL rst_btn_ignored: disp=%h sel=%0d run=%b expected all 0", disp_data, ch_sel, ch_running);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_count_carry();
    test_hour_wrap();
    test_multi_channel();
    test_lap();
    test_priority();
    test_tick_edges();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
